// File: rtl/cache_pkg.sv
// cache_pkg -- shared sizing and state encoding for the cache controller.
// WORD     : data word width
// ADDRESSL : word-address width
// INDEXL   : index width (each line holds 4 words)
// TAGL     : tag width left over after index and 2-bit word offset
`timescale 1ps/1ps
package cache_pkg;

  localparam int WORD     = 32;
  localparam int ADDRESSL = 15;
  localparam int INDEXL   = 10;
  localparam int TAGL     = ADDRESSL - INDEXL - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_READ = 2'd1,
    WRITE_MEM = 2'd2
  } state_t;

endpackage

// File: rtl/cache_controller_if.sv
// cache_controller_if -- CPU, memory and statistics signals of the cache.
// slave  : the cache controller view (takes CPU requests and memory data,
//          drives read data, ready, memory requests and counters).
// master : the environment view (CPU plus data memory).
`timescale 1ps/1ps
interface cache_controller_if #(
  parameter int WORD     = cache_pkg::WORD,
  parameter int ADDRESSL = cache_pkg::ADDRESSL
);

  // CPU side
  logic [ADDRESSL-1:0] cpuAddress;
  logic                cpuRead;
  logic                cpuWrite;
  logic [WORD-1:0]     cpuWriteData;
  logic [WORD-1:0]     cpuReadData;
  logic                ready;

  // memory side
  logic [ADDRESSL-1:0] memAddress;
  logic [ADDRESSL-1:0] memAddress0;
  logic [ADDRESSL-1:0] memAddress1;
  logic [ADDRESSL-1:0] memAddress2;
  logic [ADDRESSL-1:0] memAddress3;
  logic                memRead;
  logic                memWrite;
  logic [WORD-1:0]     memWriteData;
  logic [WORD-1:0]     memBlock0;
  logic [WORD-1:0]     memBlock1;
  logic [WORD-1:0]     memBlock2;
  logic [WORD-1:0]     memBlock3;
  logic                memReady;

  // statistics
  logic [15:0]         hitCount;
  logic [15:0]         accessCount;

  modport slave (
    input  cpuAddress, cpuRead, cpuWrite, cpuWriteData,
    input  memBlock0, memBlock1, memBlock2, memBlock3, memReady,
    output cpuReadData, ready,
    output memAddress, memAddress0, memAddress1, memAddress2, memAddress3,
    output memRead, memWrite, memWriteData,
    output hitCount, accessCount
  );

  modport master (
    output cpuAddress, cpuRead, cpuWrite, cpuWriteData,
    output memBlock0, memBlock1, memBlock2, memBlock3, memReady,
    input  cpuReadData, ready,
    input  memAddress, memAddress0, memAddress1, memAddress2, memAddress3,
    input  memRead, memWrite, memWriteData,
    input  hitCount, accessCount
  );

endinterface

// File: rtl/cache_array.sv
// cache_array -- tag, valid and data storage of the direct-mapped cache.
// Ports:
//   clk, rst             : clock, async active-high reset (valid bits only)
//   rd_index             : combinational lookup index
//   rd_valid/rd_tag/rd_block : lookup result (4 words, word 0 in element 0)
//   fill_en/fill_index/fill_tag/fill_block : whole-line fill on posedge
//   wr_en/wr_index/wr_offset/wr_data       : single-word update on posedge
`timescale 1ps/1ps
module cache_array #(
  parameter int WORD   = cache_pkg::WORD,
  parameter int INDEXL = cache_pkg::INDEXL,
  parameter int TAGW   = cache_pkg::TAGL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEXL-1:0]     rd_index,
  output logic                  rd_valid,
  output logic [TAGW-1:0]       rd_tag,
  output logic [3:0][WORD-1:0]  rd_block,
  input  logic                  fill_en,
  input  logic [INDEXL-1:0]     fill_index,
  input  logic [TAGW-1:0]       fill_tag,
  input  logic [3:0][WORD-1:0]  fill_block,
  input  logic                  wr_en,
  input  logic [INDEXL-1:0]     wr_index,
  input  logic [1:0]            wr_offset,
  input  logic [WORD-1:0]       wr_data
);

  localparam int DEPTH = 1 << INDEXL;

  logic [DEPTH-1:0]     valid_q;
  logic [TAGW-1:0]      tag_mem  [DEPTH];
  logic [3:0][WORD-1:0] data_mem [DEPTH];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_block = data_mem[rd_index];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_index] <= 1'b1;
    end
  end

  // Tag/data carry no reset; a cleared valid bit masks whatever they hold.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= fill_block;
    end else if (wr_en) begin
      data_mem[wr_index][wr_offset] <= wr_data;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// cache_controller -- direct-mapped, write-through, no-write-allocate cache.
// Ports:
//   clk  : clock, posedge
//   rst  : asynchronous active-high reset
//   bus  : cache_controller_if.slave (CPU request/response, memory block
//          read and single-word write, hit/access statistics)
// Address split: [1:0] word offset, [INDEXL+1:2] index, upper bits tag.
`timescale 1ps/1ps
module cache_controller #(
  parameter int WORD     = cache_pkg::WORD,
  parameter int ADDRESSL = cache_pkg::ADDRESSL,
  parameter int INDEXL   = cache_pkg::INDEXL
) (
  input logic               clk,
  input logic               rst,
  cache_controller_if.slave bus
);

  import cache_pkg::*;

  localparam int TAG_BITS = ADDRESSL - INDEXL - 2;

  state_t state_q, state_nxt;

  logic [ADDRESSL-3:0]  blk_q;     // line address of the outstanding miss
  logic                 missed_q;  // current request has taken a miss
  logic [15:0]          hit_cnt_q;
  logic [15:0]          acc_cnt_q;

  logic [INDEXL-1:0]    cpu_index;
  logic [TAG_BITS-1:0]  cpu_tag;
  logic [1:0]           cpu_off;

  logic                 rd_valid;
  logic [TAG_BITS-1:0]  rd_tag;
  logic [3:0][WORD-1:0] rd_block;
  logic                 hit;

  logic                 ready_c;
  logic                 fill_en;
  logic                 wr_en;
  logic                 complete;
  logic                 count_hit;

  assign cpu_off   = bus.cpuAddress[1:0];
  assign cpu_index = bus.cpuAddress[INDEXL+1:2];
  assign cpu_tag   = bus.cpuAddress[ADDRESSL-1:INDEXL+2];
  assign hit       = rd_valid && (rd_tag == cpu_tag);

  cache_array #(
    .WORD   (WORD),
    .INDEXL (INDEXL),
    .TAGW   (TAG_BITS)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_index   (cpu_index),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_block   (rd_block),
    .fill_en    (fill_en),
    .fill_index (blk_q[INDEXL-1:0]),
    .fill_tag   (blk_q[ADDRESSL-3:INDEXL]),
    .fill_block ({bus.memBlock3, bus.memBlock2, bus.memBlock1, bus.memBlock0}),
    .wr_en      (wr_en),
    .wr_index   (cpu_index),
    .wr_offset  (cpu_off),
    .wr_data    (bus.cpuWriteData)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (bus.cpuWrite) begin
          state_nxt = WRITE_MEM;
        end else if (bus.cpuRead && !hit) begin
          state_nxt = MISS_READ;
        end
      end
      MISS_READ: begin
        if (bus.memReady) begin
          state_nxt = IDLE;
        end
      end
      WRITE_MEM: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_c          = 1'b0;
    fill_en          = 1'b0;
    wr_en            = 1'b0;
    bus.cpuReadData  = '0;
    bus.memRead      = 1'b0;
    bus.memWrite     = 1'b0;
    bus.memAddress   = '0;
    bus.memWriteData = '0;
    bus.memAddress0  = '0;
    bus.memAddress1  = '0;
    bus.memAddress2  = '0;
    bus.memAddress3  = '0;
    case (state_q)
      IDLE: begin
        // Write takes priority; a pending read stalls until hit.
        if (bus.cpuWrite) begin
          ready_c = 1'b0;
        end else if (bus.cpuRead) begin
          ready_c = hit;
          if (hit) begin
            bus.cpuReadData = rd_block[cpu_off];
          end
        end else begin
          ready_c = 1'b1;
        end
      end
      MISS_READ: begin
        bus.memRead     = 1'b1;
        bus.memAddress0 = {blk_q, 2'd0};
        bus.memAddress1 = {blk_q, 2'd1};
        bus.memAddress2 = {blk_q, 2'd2};
        bus.memAddress3 = {blk_q, 2'd3};
        fill_en         = bus.memReady;
      end
      WRITE_MEM: begin
        ready_c          = 1'b1;
        bus.memWrite     = 1'b1;
        bus.memAddress   = bus.cpuAddress;
        bus.memWriteData = bus.cpuWriteData;
        wr_en            = hit;   // no-write-allocate: misses leave the cache alone
      end
      default: ready_c = 1'b0;
    endcase
  end

  assign bus.ready       = ready_c;
  assign bus.hitCount    = hit_cnt_q;
  assign bus.accessCount = acc_cnt_q;

  assign complete  = ready_c && (bus.cpuRead || bus.cpuWrite);
  assign count_hit = complete && !missed_q && !((state_q == WRITE_MEM) && !hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_q     <= '0;
      missed_q  <= 1'b0;
      hit_cnt_q <= '0;
      acc_cnt_q <= '0;
    end else begin
      if ((state_q == IDLE) && (state_nxt == MISS_READ)) begin
        blk_q    <= bus.cpuAddress[ADDRESSL-1:2];
        missed_q <= 1'b1;
      end else if (complete) begin
        missed_q <= 1'b0;
      end
      if (complete && (acc_cnt_q != 16'hFFFF)) begin
        acc_cnt_q <= acc_cnt_q + 16'd1;
      end
      if (count_hit && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
`timescale 1ps/1ps
module tb_cache_controller;

  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #50 clk = ~clk;

  cache_controller_if bus ();

  cache_controller #(
    .WORD     (WORD),
    .ADDRESSL (ADDRESSL),
    .INDEXL   (INDEXL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // data memory: mem[i] = i, block valid 4 cycles (400 ps) after memRead rises
  logic [31:0] mem [0:32767];
  int unsigned lat_cnt = 0;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = i;
  end

  always @(posedge clk) begin
    if (bus.memWrite) mem[bus.memAddress] <= bus.memWriteData;
    if (bus.memRead) lat_cnt <= lat_cnt + 1;
    else             lat_cnt <= 0;
  end

  assign bus.memReady  = bus.memRead && (lat_cnt >= 4);
  assign bus.memBlock0 = bus.memReady ? mem[bus.memAddress0] : '0;
  assign bus.memBlock1 = bus.memReady ? mem[bus.memAddress1] : '0;
  assign bus.memBlock2 = bus.memReady ? mem[bus.memAddress2] : '0;
  assign bus.memBlock3 = bus.memReady ? mem[bus.memAddress3] : '0;

  // scoreboard
  typedef struct {
    bit          is_write;
    logic [14:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb [$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every completed request is compared against the head of the queue
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.ready && (bus.cpuRead || bus.cpuWrite)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: completion at addr 0x%0h with nothing expected", bus.cpuAddress);
      end else begin
        e = sb.pop_front();
        if (e.is_write) begin
          check("mon_memwrite", 32'(bus.memWrite), 32'd1);
          check("mon_wr_addr", 32'(bus.memAddress), 32'(e.addr));
          check("mon_wr_data", bus.memWriteData, e.data);
        end else begin
          check($sformatf("mon_rd_data@%0h", e.addr), bus.cpuReadData, e.data);
        end
      end
    end
  end

  task automatic do_read(input logic [14:0] a, input logic [31:0] d, input bit miss);
    int cyc;
    bit seen;
    @(posedge clk); #1;
    sb.push_back('{1'b0, a, d});
    bus.cpuAddress = a;
    bus.cpuRead    = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    @(negedge clk);
    while (!bus.ready && cyc < 50) begin
      if (bus.memRead && !seen) begin
        seen = 1'b1;
        check($sformatf("fill_addr0@%0h", a), 32'(bus.memAddress0), 32'(a & 15'h7ffc));
        check($sformatf("fill_addr3@%0h", a), 32'(bus.memAddress3), 32'(a | 15'h0003));
      end
      cyc++;
      @(negedge clk);
    end
    if (!bus.ready) begin
      total++;
      bad++;
      $display("FAIL rd_timeout@%0h: ready still 0 after %0d cycles, required 1", a, cyc);
    end
    check($sformatf("rd_stall@%0h", a), 32'(cyc != 0), 32'(miss));
    check($sformatf("rd_memread@%0h", a), 32'(seen), 32'(miss));
    @(posedge clk); #1;
    bus.cpuRead    = 1'b0;
    bus.cpuAddress = '0;
  endtask

  task automatic do_write(input logic [14:0] a, input logic [31:0] d);
    int cyc;
    int pulses;
    @(posedge clk); #1;
    sb.push_back('{1'b1, a, d});
    bus.cpuAddress   = a;
    bus.cpuWriteData = d;
    bus.cpuWrite     = 1'b1;
    cyc    = 0;
    pulses = 0;
    @(negedge clk);
    while (!bus.ready && cyc < 50) begin
      if (bus.memWrite) pulses++;
      cyc++;
      @(negedge clk);
    end
    if (bus.memWrite) pulses++;
    check($sformatf("wr_stall@%0h", a), 32'(cyc), 32'd1);
    @(posedge clk); #1;
    bus.cpuWrite     = 1'b0;
    bus.cpuAddress   = '0;
    bus.cpuWriteData = '0;
    @(negedge clk);
    if (bus.memWrite) pulses++;
    check($sformatf("wr_pulses@%0h", a), 32'(pulses), 32'd1);
  endtask

  task automatic check_counts(input string name, input int h, input int a);
    check({name, "_hit"}, 32'(bus.hitCount), 32'(h));
    check({name, "_acc"}, 32'(bus.accessCount), 32'(a));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpuAddress   = '0;
    bus.cpuRead      = 1'b0;
    bus.cpuWrite     = 1'b0;
    bus.cpuWriteData = '0;
    repeat (3) @(negedge clk);
    check("rst_memread", 32'(bus.memRead), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(bus.ready), 32'd1);
    check("idle_rdata", bus.cpuReadData, 32'd0);
    check("idle_memwrite", 32'(bus.memWrite), 32'd0);
    check("idle_memaddr0", 32'(bus.memAddress0), 32'd0);
    check_counts("reset", 0, 0);

    do_read(15'h0004, 32'h0000_0004, 1'b1);
    check_counts("cold", 0, 1);
    do_read(15'h0004, 32'h0000_0004, 1'b0);
    do_read(15'h0005, 32'h0000_0005, 1'b0);
    check_counts("hits", 2, 3);

    do_read(15'h1004, 32'h0000_1004, 1'b1);
    do_read(15'h0004, 32'h0000_0004, 1'b1);
    check_counts("conflict", 2, 5);

    do_write(15'h0006, 32'h0000_DEAD);
    check_counts("wr_hit", 3, 6);
    do_read(15'h0006, 32'h0000_DEAD, 1'b0);
    check_counts("rd_after_wr", 4, 7);

    do_write(15'h2008, 32'h0000_BEEF);
    check_counts("wr_miss", 4, 8);
    do_read(15'h2008, 32'h0000_BEEF, 1'b1);
    check_counts("rd_after_wrmiss", 4, 9);

    // reset in the second MISS_READ cycle
    @(posedge clk); #1;
    bus.cpuAddress = 15'h0010;
    bus.cpuRead    = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #20;
    check("pre_rst_memread", 32'(bus.memRead), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_memread", 32'(bus.memRead), 32'd0);
    check_counts("mid_rst", 0, 0);
    bus.cpuRead    = 1'b0;
    bus.cpuAddress = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_read(15'h0010, 32'h0000_0010, 1'b1);
    do_read(15'h0010, 32'h0000_0010, 1'b0);
    do_read(15'h0004, 32'h0000_0004, 1'b1);
    check_counts("post_rst", 1, 3);

    repeat (2) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
